// File: rtl/npc_arb_pkg.sv
// Shared types and default widths for the NPC memory-port arbiter.
// Optional feature macro used by the arbiter: NPC_ARB_TIMEOUT_EN.
package npc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam int ARB_ADDR_W         = 32;
  localparam int ARB_DATA_W         = 32;
  localparam int ARB_MASK_W         = 8;
  localparam int ARB_TIMEOUT_CYCLES = 255;
  localparam int ARB_WCNT_W         = 8;

  // grant bit positions inside the picker's one-hot vector
  localparam int GNT_IFU = 0;
  localparam int GNT_LSU = 1;

endpackage

// File: rtl/npc_arb_pick.sv
// Two-way round-robin picker. A lone requester always wins; on a tie the
// requester that did not own the previous transaction wins.
module npc_arb_pick
  import npc_arb_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  owner_e     last_owner,
  output logic [1:0] grant
);

  // one-hot grant; zero when nobody requests
  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      if (last_owner == OWN_LSU) grant[GNT_IFU] = 1'b1;
      else                       grant[GNT_LSU] = 1'b1;
    end else begin
      grant[GNT_IFU] = ifu_valid;
      grant[GNT_LSU] = lsu_valid;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares the single NPC memory port between instruction fetch and the
// load/store unit; one transaction in flight at a time.
// Optional feature macro: NPC_ARB_TIMEOUT_EN (WAIT-state timeout with a
// sticky timeout_err flag). Without it WAIT waits forever.
module npc_mem_arbiter
  import npc_arb_pkg::*;
#(
  parameter int ADDR_W         = ARB_ADDR_W,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int MASK_W         = ARB_MASK_W,
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              timeout_err
);

  localparam logic [ARB_WCNT_W-1:0] TO_LIM = ARB_WCNT_W'(TIMEOUT_CYCLES);

  arb_state_e        state_q, state_d;
  // owner of the current transaction; also the round-robin history, since
  // both are updated on the same accept
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [1:0]        grant;
  logic              resp_fire;
  logic              timeout_hit;
  logic              done;

  npc_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (owner_q),
    .grant      (grant)
  );

  // grant only exists for a valid requester, so ready implies accept
  assign ifu_req_ready = (state_q == IDLE) && grant[GNT_IFU];
  assign lsu_req_ready = (state_q == IDLE) && grant[GNT_LSU];

`ifdef NPC_ARB_TIMEOUT_EN
  logic [ARB_WCNT_W-1:0] wcnt_q;
  logic                  terr_q;

  // counts WAIT cycles without a response; restarts on every WAIT entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q <= '0;
    end else if (state_q != WAIT && state_d == WAIT) begin
      wcnt_q <= '0;
    end else if (state_q == WAIT && !mem_resp_valid) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  // sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             terr_q <= 1'b0;
    else if (timeout_hit) terr_q <= 1'b1;
  end

  assign timeout_hit = (state_q == WAIT) && !mem_resp_valid && (wcnt_q == TO_LIM);
  assign timeout_err = terr_q;
`else
  logic unused_to_lim;
  assign unused_to_lim = ^TO_LIM;
  assign timeout_hit   = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  // a real response always wins over a timeout in the same cycle
  assign resp_fire = (state_q == WAIT) && mem_resp_valid;
  assign done      = resp_fire || timeout_hit;

  // next-state: IDLE accepts, REQ holds until handshake, WAIT until done
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ifu_req_ready || lsu_req_ready) state_d = REQ;
      REQ:     if (mem_req_ready)                  state_d = WAIT;
      WAIT:    if (done)                           state_d = IDLE;
      default:                                     state_d = IDLE;
    endcase
  end

  // state register; reset mid-transaction simply drops it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // capture the winner's request fields on accept and hold them through REQ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_IFU;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (ifu_req_ready) begin
      owner_q <= OWN_IFU;
      addr_q  <= ifu_addr;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (lsu_req_ready) begin
      owner_q <= OWN_LSU;
      addr_q  <= lsu_addr;
      wen_q   <= lsu_wen;
      wdata_q <= lsu_wdata;
      wmask_q <= lsu_wen ? lsu_wmask : '0;
    end
  end

  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  // response steering: only the owner sees data; stores and timeouts return 0
  always_comb begin
    ifu_resp_valid = done && (owner_q == OWN_IFU);
    lsu_resp_valid = done && (owner_q == OWN_LSU);
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    if (resp_fire && owner_q == OWN_IFU)           ifu_rdata = mem_rdata;
    if (resp_fire && owner_q == OWN_LSU && !wen_q) lsu_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Self-checking bench for npc_mem_arbiter: table of single transactions with
// a response scoreboard, plus hand sequences for tie-break, reset abort and
// (when NPC_ARB_TIMEOUT_EN is defined) the WAIT timeout.
module tb_npc_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [MW-1:0] lsu_wmask;
  logic          mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;
  logic          timeout_err;

  npc_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // who: 0 = IFU, 1 = LSU
  typedef struct {
    logic          who;
    logic [AW-1:0] addr;
    logic          wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    int            rdy_dly;
    int            rsp_dly;
    logic          rsp_in_req;
    logic [DW-1:0] mrdata;
    logic [MW-1:0] exp_wmask;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic          who;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic check_resp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk("resp_valid", {ifu_resp_valid, lsu_resp_valid}, e.who ? 2'b01 : 2'b10);
      chk("resp_rdata", e.who ? lsu_rdata : ifu_rdata, e.rdata);
      chk("nonowner_rdata", e.who ? ifu_rdata : lsu_rdata, '0);
    end
  endtask

  task automatic do_txn(input vec_t v);
    @(negedge clk);
    if (v.who) begin
      lsu_req_valid = 1'b1; lsu_addr = v.addr; lsu_wen = v.wen;
      lsu_wdata = v.wdata;  lsu_wmask = v.wmask;
    end else begin
      ifu_req_valid = 1'b1; ifu_addr = v.addr;
    end
    #1 chk("accept_ready", {ifu_req_ready, lsu_req_ready}, v.who ? 2'b01 : 2'b10);
    sb.push_back('{v.who, v.exp_rdata});
    @(posedge clk);
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    for (int d = 0; d <= v.rdy_dly; d++) begin
      if (d > 0) @(negedge clk);
      mem_req_ready  = (d == v.rdy_dly);
      mem_resp_valid = v.rsp_in_req;
      mem_rdata      = 32'hBAD0_0000;
      #1;
      chk("req_valid", mem_req_valid, 1'b1);
      chk("req_addr", mem_addr, v.addr);
      chk("req_wen", mem_wen, v.who & v.wen);
      chk("req_wmask", mem_wmask, v.exp_wmask);
      if (v.who) chk("req_wdata", mem_wdata, v.wdata);
      chk("req_no_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      @(posedge clk);
    end
    for (int r = 0; r <= v.rsp_dly; r++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = (r == v.rsp_dly);
      mem_rdata      = v.mrdata;
      #1;
      chk("wait_req_low", mem_req_valid, 1'b0);
      if (r == v.rsp_dly) check_resp();
      else chk("wait_no_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
      @(posedge clk);
    end
    // response held one extra cycle lands in IDLE and must be ignored
    @(negedge clk);
    #1;
    chk("idle_late_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    chk("idle_req_low", mem_req_valid, 1'b0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 0, 1'b0,
                32'h0000_0413, 8'h00, 32'h0000_0413};
    vecs[1] = '{1'b1, 32'h8000_0100, 1'b1, 32'h1234_5678, 8'h0F, 4, 0, 1'b0,
                32'hDEAD_BEEF, 8'h0F, 32'h0};
    vecs[2] = '{1'b1, 32'h8000_0200, 1'b0, 32'h5555_AAAA, 8'hFF, 1, 2, 1'b0,
                32'hCAFE_F00D, 8'h00, 32'hCAFE_F00D};
    vecs[3] = '{1'b0, 32'h8000_0004, 1'b0, 32'h0, 8'h00, 2, 1, 1'b1,
                32'h0010_0073, 8'h00, 32'h0010_0073};
    vecs[4] = '{1'b1, 32'h8000_0300, 1'b0, 32'h0, 8'h00, 3, 0, 1'b1,
                32'h0BAD_C0DE, 8'h00, 32'h0BAD_C0DE};
    vecs[5] = '{1'b1, 32'h8000_0404, 1'b1, 32'hA5A5_0F0F, 8'hC3, 0, 6, 1'b0,
                32'h7777_7777, 8'hC3, 32'h0};

    rst = 1'b0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;

    // reset state
    @(negedge clk); #1;
    chk("rst_readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
    chk("rst_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    chk("rst_terr", timeout_err, 1'b0);
    @(negedge clk); rst = 1'b1;

    // tie right after reset: LSU, IFU, LSU, IFU with 3-cycle transactions
    @(negedge clk);
    ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0020; lsu_wen = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0000_0055;
    for (int c = 0; c < 12; c++) begin
      logic lsu_turn;
      if (c > 0) @(negedge clk);
      lsu_turn = ((c / 3) % 2) == 0;
      #1;
      case (c % 3)
        0: chk("tie_grant", {ifu_req_ready, lsu_req_ready}, lsu_turn ? 2'b01 : 2'b10);
        1: begin
          chk("tie_req_valid", mem_req_valid, 1'b1);
          chk("tie_req_addr", mem_addr, lsu_turn ? 32'h8000_0020 : 32'h8000_0010);
          chk("tie_no_resp_in_req", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        end
        default: begin
          chk("tie_resp", {ifu_resp_valid, lsu_resp_valid}, lsu_turn ? 2'b01 : 2'b10);
          chk("tie_rdata", lsu_turn ? lsu_rdata : ifu_rdata, 32'h0000_0055);
          chk("tie_readies_busy", {ifu_req_ready, lsu_req_ready}, 2'b00);
        end
      endcase
      @(posedge clk);
    end
    @(negedge clk);
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;

    // table-driven single transactions
    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // reset in WAIT aborts the transaction; a later response is dropped
    @(negedge clk);
    mem_resp_valid = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0800;
    #1 chk("abort_accept", ifu_req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk); ifu_req_valid = 0; mem_req_ready = 1;
    @(posedge clk);
    @(negedge clk); mem_req_ready = 0;
    #1 chk("abort_wait_no_resp", ifu_resp_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_req_valid", mem_req_valid, 1'b0);
    chk("abort_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask}, '0);
    chk("abort_readies", {ifu_req_ready, lsu_req_ready}, 2'b00);
    @(posedge clk);
    @(negedge clk); rst = 1'b1; mem_resp_valid = 1; mem_rdata = 32'h1111_2222;
    #1 chk("abort_late_resp", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
    @(posedge clk);
    do_txn(vecs[0]);

`ifdef NPC_ARB_TIMEOUT_EN
    begin
      int hit;
      hit = -1;
      @(negedge clk);
      mem_resp_valid = 0;
      ifu_req_valid = 1; ifu_addr = 32'h8000_0C00;
      #1 chk("to_accept", ifu_req_ready, 1'b1);
      @(posedge clk);
      @(negedge clk); ifu_req_valid = 0; mem_req_ready = 1;
      @(posedge clk);
      for (int k = 0; k < 40 && hit < 0; k++) begin
        @(negedge clk); mem_req_ready = 0;
        #1;
        if (ifu_resp_valid) begin
          hit = k;
          chk("to_rdata", ifu_rdata, '0);
        end
        @(posedge clk);
      end
      chk("to_cycle", 64'(hit), 64'(TO));
      @(negedge clk); #1;
      chk("to_err_set", timeout_err, 1'b1);
      chk("to_idle", mem_req_valid, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      chk("to_err_sticky", timeout_err, 1'b1);
    end
`else
    chk("terr_tied", timeout_err, 1'b0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
